uart_rx_word: RTL

Serial receiver for the UART link driven by the team's 16-bit two-byte transmitter. It samples the idle-high `rx` line with a 16x oversampling clock and detects start bits. It reassembles two back-to-back 8N1 frames (low byte first, LSB first) into one 16-bit word, which it presents with a one-cycle `valid` strobe. It sits between the board's serial input pin and the word-consuming logic, and flags framing errors and inter-byte timeouts.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 15 +
 rtl/uart_rx_word.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, defaults and timing constants for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } rx_state_t;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_GAP_BITS = 4;
    localparam int BAUD = 9600;
    localparam int BIT_PERIOD_NS = 1_000_000_000 / BAUD;
    // Number of oversample ticks the receiver waits between bytes of a word
    function automatic int gap_ticks(input int oversample, input int gap_bits);
        return oversample * gap_bits;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous input, resets to the idle-high level
module uart_rx_sync (
    input  logic clk_153k6hz,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] ff;
    // Shift the raw input through two flops; reset to 1 so an idle line looks idle
    always_ff @(posedge clk_153k6hz) begin
        if (rst) ff <= 2'b11;
        else ff <= {ff[0], d};
    end
    assign q = ff[1];
endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: receives two back-to-back 8N1 bytes and presents them as one 16-bit word
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input  logic        clk_153k6hz,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] data,
    output logic        valid,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int GL = gap_ticks(OVERSAMPLE, GAP_BITS);
    localparam int GW = $clog2(GL + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GL - 1);

    rx_state_t state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [2:0] bit_idx, bit_n;
    logic byte_idx, byte_n;
    logic [7:0] shreg, sh_n, byte0, b0_n;
    logic [15:0] data_n;
    logic valid_n, fe_n, to_n, armed, armed_n;
    logic rx_s;

    uart_rx_sync u_sync (
        .clk_153k6hz(clk_153k6hz),
        .rst(rst),
        .d(rx),
        .q(rx_s)
    );

    // Register all FSM and datapath state; error and valid strobes are registered pulses
    always_ff @(posedge clk_153k6hz) begin
        if (rst) begin
            state <= ST_IDLE;
            tick <= '0;
            gap_cnt <= '0;
            bit_idx <= '0;
            byte_idx <= 1'b0;
            shreg <= '0;
            byte0 <= '0;
            data <= '0;
            valid <= 1'b0;
            frame_err <= 1'b0;
            timeout_err <= 1'b0;
            armed <= 1'b1;
        end else begin
            state <= state_n;
            tick <= tick_n;
            gap_cnt <= gap_n;
            bit_idx <= bit_n;
            byte_idx <= byte_n;
            shreg <= sh_n;
            byte0 <= b0_n;
            data <= data_n;
            valid <= valid_n;
            frame_err <= fe_n;
            timeout_err <= to_n;
            armed <= armed_n;
        end
    end

    // Next-state logic: start qualification, bit-centre sampling, stop check and inter-byte gap
    always_comb begin
        state_n = state;
        tick_n = tick + TW'(1);
        gap_n = gap_cnt;
        bit_n = bit_idx;
        byte_n = byte_idx;
        sh_n = shreg;
        b0_n = byte0;
        data_n = data;
        valid_n = 1'b0;
        fe_n = 1'b0;
        to_n = 1'b0;
        armed_n = armed | rx_s;
        case (state)
            ST_IDLE: begin
                tick_n = '0;
                byte_n = 1'b0;
                state_n = (armed && !rx_s) ? ST_START : ST_IDLE;
            end
            ST_START: begin
                if (tick == HALF_LAST) begin
                    tick_n = '0;
                    bit_n = '0;
                    state_n = !rx_s ? ST_DATA : (byte_idx ? ST_GAP : ST_IDLE);
                end
            end
            ST_DATA: begin
                if (tick == BIT_LAST) begin
                    tick_n = '0;
                    sh_n = {rx_s, shreg[7:1]};
                    bit_n = bit_idx + 3'd1;
                    state_n = (bit_idx == 3'd7) ? ST_STOP : ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick == BIT_LAST) begin
                    tick_n = '0;
                    state_n = ST_IDLE;
                    if (!rx_s) begin
                        fe_n = 1'b1;
                        armed_n = 1'b0;
                    end else if (!byte_idx) begin
                        b0_n = shreg;
                        byte_n = 1'b1;
                        gap_n = GW'(1);
                        state_n = ST_GAP;
                    end else begin
                        data_n = {shreg, byte0};
                        valid_n = 1'b1;
                        armed_n = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                tick_n = '0;
                gap_n = gap_cnt + GW'(1);
                if (!rx_s) begin
                    state_n = ST_START;
                end else if (gap_cnt == GAP_LAST) begin
                    to_n = 1'b1;
                    armed_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
endmodule
